// File: rtl/simon_round_sequencer.sv
// Round controller for the LED memory game: shows the first `level` pattern colours,
// then checks each button press against the pattern and reports pass, fail or timeout.
module simon_round_sequencer #(
   parameter int STAGES        = 5,
   parameter int ON_TICKS      = 4,
   parameter int OFF_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 40
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tick,
   input  logic                start,
   input  logic                abort,
   input  logic [2:0]          level,
   input  logic [2*STAGES-1:0] pattern,
   input  logic [3:0]          buttonIn,
   output logic                led_on,
   output logic [1:0]          led_color,
   output logic                busy,
   output logic                listening,
   output logic                stage_pass,
   output logic                stage_fail,
   output logic                fail_timeout
);

   localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int MAXT = (ON_TICKS > OFF_TICKS)
                         ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                         : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
   localparam int CW   = $clog2(MAXT) + 1;

   typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, RELEASE, PASS, FAIL} state_t;

   state_t              state;
   logic [2*STAGES-1:0] pat;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       last;
   logic [IW-1:0]       idx_inc;
   logic [CW-1:0]       cnt;
   logic                to_cause;
   logic [1:0]          cur_entry;
   logic [1:0]          nxt_entry;
   logic [1:0]          press_color;
   logic                press_single;

   function automatic logic [IW-1:0] clamp_last(input logic [2:0] lv);
      if (lv == 3'd0) return '0;
      if (int'(lv) > STAGES) return IW'(STAGES - 1);
      return IW'(int'(lv) - 1);
   endfunction

   always_comb begin
      idx_inc      = idx + 1'b1;
      cur_entry    = pat[2*idx +: 2];
      nxt_entry    = pat[2*idx_inc +: 2];
      press_color  = 2'd0;
      press_single = 1'b1;
      case (buttonIn)
         4'b0001: press_color = 2'd0;
         4'b0010: press_color = 2'd1;
         4'b0100: press_color = 2'd2;
         4'b1000: press_color = 2'd3;
         default: press_single = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pat          <= '0;
         idx          <= '0;
         last         <= '0;
         cnt          <= '0;
         to_cause     <= 1'b0;
         led_on       <= 1'b0;
         led_color    <= '0;
         busy         <= 1'b0;
         listening    <= 1'b0;
         stage_pass   <= 1'b0;
         stage_fail   <= 1'b0;
         fail_timeout <= 1'b0;
      end else begin
         stage_pass <= 1'b0;
         stage_fail <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            to_cause  <= 1'b0;
            led_on    <= 1'b0;
            led_color <= '0;
            busy      <= 1'b0;
            listening <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  pat          <= pattern;
                  last         <= clamp_last(level);
                  idx          <= '0;
                  cnt          <= '0;
                  to_cause     <= 1'b0;
                  fail_timeout <= 1'b0;
                  busy         <= 1'b1;
                  led_on       <= 1'b1;
                  led_color    <= pattern[1:0];
                  state        <= SHOW_ON;
               end
               SHOW_ON: if (tick) begin
                  if (cnt == CW'(ON_TICKS - 1)) begin
                     cnt       <= '0;
                     led_on    <= 1'b0;
                     led_color <= '0;
                     state     <= SHOW_OFF;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SHOW_OFF: if (tick) begin
                  if (cnt == CW'(OFF_TICKS - 1)) begin
                     cnt <= '0;
                     if (idx == last) begin
                        idx       <= '0;
                        listening <= 1'b1;
                        state     <= WAIT_IN;
                     end else begin
                        idx       <= idx_inc;
                        led_on    <= 1'b1;
                        led_color <= nxt_entry;
                        state     <= SHOW_ON;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // A press takes precedence over a tick that would expire the timeout.
               WAIT_IN: if (buttonIn != '0) begin
                  listening <= 1'b0;
                  if (press_single && press_color == cur_entry) begin
                     led_on    <= 1'b1;
                     led_color <= press_color;
                     state     <= RELEASE;
                  end else begin
                     state <= FAIL;
                  end
               end else if (tick) begin
                  if (cnt == CW'(TIMEOUT_TICKS - 1)) begin
                     listening <= 1'b0;
                     to_cause  <= 1'b1;
                     state     <= FAIL;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RELEASE: if (buttonIn == '0) begin
                  led_on    <= 1'b0;
                  led_color <= '0;
                  if (idx == last) begin
                     stage_pass <= 1'b1;
                     state      <= PASS;
                  end else begin
                     idx       <= idx_inc;
                     cnt       <= '0;
                     listening <= 1'b1;
                     state     <= WAIT_IN;
                  end
               end
               PASS: begin
                  busy  <= 1'b0;
                  idx   <= '0;
                  state <= IDLE;
               end
               // FAIL spans two cycles so the pulse lands one cycle after entry, with busy still high.
               FAIL: if (!stage_fail) begin
                  stage_fail   <= 1'b1;
                  fail_timeout <= to_cause;
               end else begin
                  busy  <= 1'b0;
                  idx   <= '0;
                  cnt   <= '0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
